// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared screen RAM widths and arbiter state encoding
package vram_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RD   = 2'd2,
    ST_ACK  = 2'd3
  } arb_state_t;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit saturating up-counter with synchronous clear
module sat_counter8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  // clear wins over increment; the count sticks at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (inc && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - screen RAM arbiter, video has absolute priority over CPU
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        stall_max
);

  arb_state_t        state, next_state;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              latch_en;
  logic              rd_cap;
  logic              cnt_clr;
  logic              cnt_inc;
  logic [7:0]        wait_cnt;

  assign cpu_ack   = (state == ST_ACK);
  assign cpu_wait  = cpu_req & ~cpu_ack;
  // video data is the RAM output in the cycle after its request, zero otherwise
  assign vid_data  = vid_valid ? mem_rdata : '0;
  assign mem_wdata = lat_wdata;

  sat_counter8 u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (wait_cnt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // next state, RAM port mux and control strobes
  always_comb begin
    next_state = state;
    mem_addr   = vid_req ? vid_addr : lat_addr;
    mem_we     = 1'b0;
    latch_en   = 1'b0;
    rd_cap     = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req && !cpu_ack) begin
          latch_en   = 1'b1;
          cnt_clr    = 1'b1;
          next_state = ST_PEND;
        end
      end
      ST_PEND: begin
        if (vid_req) begin
          cnt_inc = 1'b1;
        end else if (lat_we) begin
          mem_we     = 1'b1;
          next_state = ST_ACK;
        end else begin
          next_state = ST_RD;
        end
      end
      ST_RD: begin
        rd_cap     = 1'b1;
        next_state = ST_ACK;
      end
      ST_ACK: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // CPU request capture; cleared on reset so an abandoned access cannot resurface
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
    end else if (latch_en) begin
      lat_addr  <= cpu_addr;
      lat_wdata <= cpu_wdata;
      lat_we    <= cpu_we;
    end
  end

  // CPU read data, video strobe and worst-case stall tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata <= '0;
      vid_valid <= 1'b0;
      stall_max <= 8'd0;
    end else begin
      vid_valid <= vid_req;
      if (rd_cap) begin
        cpu_rdata <= mem_rdata;
      end
      if (state == ST_ACK) begin
        stall_max <= max8(stall_max, wait_cnt);
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, screen RAM address width (8 KB).
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have ports: clk  in  1  sole clock (25 MHz pixel clock domain).
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: vid_req  in  1  video fetcher read request, this cycle.
REQ-006 SHALL have ports: vid_addr  in  ADDR_W  video read address.
REQ-007 SHALL have ports: vid_data  out  DATA_W  video read data; vid_valid  out  1  data-valid strobe.
REQ-008 SHALL have ports: cpu_req  in  1  CPU access request, level, held until ack.
REQ-009 SHALL have ports: cpu_we  in  1  1 = write.
REQ-010 SHALL have ports: cpu_addr  in  ADDR_W  CPU address; cpu_wdata  in  DATA_W  write data.
REQ-011 SHALL have ports: cpu_rdata  out  DATA_W  read data, registered.
REQ-012 SHALL have ports: cpu_ack  out  1  one-cycle completion pulse; cpu_wait  out  1  CPU stall (feeds Z80 WAIT).
REQ-013 SHALL have ports: mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  DATA_W  to single-port synchronous RAM.
REQ-014 SHALL have ports: mem_rdata  in  DATA_W  RAM read data, valid one cycle after address.
REQ-015 SHALL have ports: stall_max  out  8  longest CPU wait observed, in cycles, saturating.

Function
REQ-016 Video SHALL have absolute priority: vid_req=1 drives mem_addr=vid_addr, mem_we=0 in that same cycle (combinational mux).
REQ-017 vid_valid SHALL be 1 exactly one cycle after a vid_req cycle; vid_data SHALL equal mem_rdata in that cycle. Video latency is fixed at 1 and never stalls.
REQ-018 FSM states: IDLE, PEND, RD, ACK.
REQ-019 IDLE: cpu_req=1 and cpu_ack=0 SHALL latch cpu_addr, cpu_wdata, cpu_we into internal registers and go to PEND.
REQ-020 PEND with vid_req=1: SHALL stay in PEND and increment the wait counter.
REQ-021 PEND with vid_req=0: SHALL drive mem_addr from the latched address. A write SHALL assert mem_we with the latched data and go to ACK. A read SHALL go to RD.
REQ-022 RD: SHALL capture mem_rdata into cpu_rdata and go to ACK. The RAM port is free for video in this cycle.
REQ-023 ACK: cpu_ack=1 for one cycle, then IDLE. A new request SHALL NOT be latched in the same cycle as cpu_ack.
REQ-024 cpu_wait SHALL be cpu_req AND NOT (state==ACK).
REQ-025 mem_we SHALL be 1 only in a granted PEND write cycle. mem_addr SHALL be the latched CPU address when no requester is granted.
REQ-026 Wait counter: 8-bit, saturates at 255, cleared on entry to PEND. On each ACK, stall_max SHALL become max(stall_max, counter).
REQ-027 If cpu_req drops while in PEND, the latched access SHALL still complete; ack is still pulsed.
REQ-028 Best-case CPU latency: write, request to ack = 2 cycles; read = 3 cycles.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE; cpu_ack=0, vid_valid=0, cpu_rdata=0, vid_data path register=0, stall_max=0, counter=0, mem_we=0.
REQ-030 Reset mid-access SHALL abandon the access with no write issued afterwards. The first request after release SHALL be latched normally.

Structure
REQ-031 ADDR_W/DATA_W defaults and FSM state encodings SHALL live in shared package vram_pkg, reused by the video fetcher and the CPU bus glue.
REQ-032 A single sub-module, sat_counter8 (saturating up-counter with clear), SHALL implement the wait counter. All else is flat.

Verification
REQ-033 Write with vid_req=0: cpu_req, we=1, addr 0x1800, data 0x47 -> mem_we pulse at 0x1800/0x47 one cycle later; cpu_ack 2 cycles after request.
REQ-034 Read contention: vid_req held high 5 cycles while CPU reads 0x0000 (RAM holds 0xAA) -> no CPU grant during those cycles; cpu_rdata=0xAA; stall_max=5.
REQ-035 Video cadence: vid_req at x[3:0]=0 and 2 every 16 cycles, addresses 0x0123/0x1A04 -> vid_valid one cycle after each; data matches RAM; CPU traffic never delays video.
REQ-036 Write blocked by video: CPU write issued in the same cycle as vid_req -> no mem_we in that cycle; write lands in the next free cycle; RAM contents are correct.
REQ-037 Reset mid-PEND: assert rst_n=0 during a pending write to 0x0010 -> RAM at 0x0010 unchanged; all outputs at reset values; the next access completes normally.
REQ-038 Saturation: vid_req held high for 300 cycles -> stall_max=255.
